// File: rtl/key_expand_seq.sv
// Sequential FIPS-197 key schedule: one expanded word per cycle into a register array.
// Optional macro KEY_EXPAND_ZEROIZE_EN enables the zeroize key-erase path.
module key_expand_seq #(
    parameter int MAX_KEY_W = 256,
    parameter int NR_MAX    = MAX_KEY_W / 32 + 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           key_len,
    input  logic [MAX_KEY_W-1:0] key_in,
    input  logic                 zeroize,
    input  logic [3:0]           rk_idx,
    output logic [127:0]         rk_out,
    output logic                 busy,
    output logic                 done,
    output logic                 key_ready,
    output logic                 err
);
    localparam int NW = 4 * (NR_MAX + 1);
    localparam int KW = MAX_KEY_W / 32;
    localparam logic [1:0] MAX_LEN = 2'((MAX_KEY_W - 128) / 64);

    typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

    state_t               state_q, state_d;
    logic [31:0]          w_q [NW];
    logic [31:0]          w_d [NW];
    logic [MAX_KEY_W-1:0] key_q, key_d;
    logic [1:0]           len_q, len_d;
    logic [5:0]           i_q, i_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 key_ready_q, key_ready_d;
    logic                 err_q, err_d;

    logic [3:0]  nr;
    logic [5:0]  nk, last;
    logic [31:0] prev, temp;
    logic        accept, reject, zero_req;

`ifdef KEY_EXPAND_ZEROIZE_EN
    assign zero_req = zeroize;
`else
    logic unused_zeroize;
    assign unused_zeroize = zeroize;
    assign zero_req       = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    always_comb begin
        case (len_q)
            2'd0:    nr = 4'd10;
            2'd1:    nr = 4'd12;
            default: nr = 4'd14;
        endcase
        nk   = 6'(nr) - 6'd6;
        last = {nr, 2'b11};
    end

    assign accept = (state_q == IDLE) && start && !zero_req && (key_len <= MAX_LEN);
    assign reject = (state_q == IDLE) && start && !zero_req && (key_len > MAX_LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = LOAD;
            LOAD: state_d = GEN;
            GEN:  if (i_q == last) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
        if (zero_req) state_d = IDLE;
    end

    always_comb begin
        w_d         = w_q;
        key_d       = key_q;
        len_d       = len_q;
        i_d         = i_q;
        cnt_d       = cnt_q;
        rcon_d      = rcon_q;
        key_ready_d = key_ready_q;
        err_d       = reject;
        prev        = '0;
        temp        = '0;
        if (accept) begin
            key_d       = key_in;
            len_d       = key_len;
            key_ready_d = 1'b0;
        end
        case (state_q)
            LOAD: begin
                for (int j = 0; j < KW; j++)
                    if (6'(j) < nk) w_d[j] = key_q[MAX_KEY_W-1-32*j -: 32];
                i_d    = nk;
                cnt_d  = 3'd0;
                rcon_d = 8'h01;
            end
            GEN: begin
                // cnt_q tracks i mod Nk so Nk=6 needs no divider.
                prev = w_q[i_q - 6'd1];
                temp = prev;
                if (cnt_q == 3'd0) begin
                    temp   = sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h000000};
                    rcon_d = xtime(rcon_q);
                end else if (nk == 6'd8 && cnt_q == 3'd4) begin
                    temp = sub_word(prev);
                end
                w_d[i_q] = w_q[i_q - nk] ^ temp;
                i_d      = i_q + 6'd1;
                cnt_d    = (cnt_q == 3'(nk - 6'd1)) ? 3'd0 : cnt_q + 3'd1;
                if (i_q == last) key_ready_d = 1'b1;
            end
            default: ;
        endcase
        if (zero_req) begin
            for (int k = 0; k < NW; k++) w_d[k] = '0;
            key_d       = '0;
            key_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_q         <= '{default: '0};
            key_q       <= '0;
            len_q       <= 2'd0;
            i_q         <= 6'd0;
            cnt_q       <= 3'd0;
            rcon_q      <= 8'h01;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            w_q         <= w_d;
            key_q       <= key_d;
            len_q       <= len_d;
            i_q         <= i_d;
            cnt_q       <= cnt_d;
            rcon_q      <= rcon_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        busy      = (state_q == LOAD) || (state_q == GEN);
        done      = (state_q == DONE);
        key_ready = key_ready_q;
        err       = err_q;
        rk_out    = '0;
        if (key_ready_q && rk_idx <= nr)
            rk_out = {w_q[{rk_idx, 2'b00}], w_q[{rk_idx, 2'b01}],
                      w_q[{rk_idx, 2'b10}], w_q[{rk_idx, 2'b11}]};
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// Scoreboard bench for key_expand_seq: expected round keys queued at launch, checked after done.
module tb_key_expand_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         zeroize = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_out;
    logic         busy, done, key_ready, err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] val;
    } exp_t;
    exp_t sb[$];

    localparam logic [127:0] K128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192   = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256A  = 256'h1212121269696969343434343434343456565656565656567878787878787878;
    localparam logic [255:0] K256B  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK14_B = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    always #5 clk = ~clk;

    key_expand_seq dut (
        .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key_in(key_in),
        .zeroize(zeroize), .rk_idx(rk_idx), .rk_out(rk_out), .busy(busy),
        .done(done), .key_ready(key_ready), .err(err)
    );

    task automatic push(input logic [3:0] idx, input logic [127:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic launch(input logic [1:0] len, input logic [255:0] key);
        key_len = len;
        key_in  = key;
        start   = 1'b1;
    endtask

    task automatic wait_done(input int exp_lat, input int poke_cyc);
        int lat;
        int bad_busy;
        lat = 0;
        bad_busy = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start   = 1'b0;
                key_in  = ~key_in;
                key_len = 2'd1;
                checks++;
                if (key_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL kr_drop got=%b exp=0", key_ready);
                end
            end
            if (c == poke_cyc) begin
                start   = 1'b1;
                key_len = 2'd2;
            end
            if (c == poke_cyc + 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (busy !== 1'b1) bad_busy++;
        end
        start = 1'b0;
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL latency got=%0d exp=%0d", lat, exp_lat);
        end
        checks++;
        if (bad_busy != 0) begin
            failures++;
            $display("FAIL busy_hold low_cycles=%0d exp=0", bad_busy);
        end
    endtask

    task automatic after_done();
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got=%b exp=0", done);
        end
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL key_ready got=%b exp=1", key_ready);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rk_idx = e.idx;
            #1;
            checks++;
            if (rk_out !== e.val) begin
                failures++;
                $display("FAIL rk[%0d] got=%h exp=%h", e.idx, rk_out, e.val);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            rk_idx = 4'(i);
            #1;
            if (rk_out !== 128'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s nonzero_keys=%0d exp=0", tag, bad);
        end
    endtask

    task automatic test_reset();
        rk_idx = 4'd0;
        #1;
        checks++;
        if ({busy, done, err, key_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, err, key_ready});
        end
        checks++;
        if (rk_out !== 128'h0) begin
            failures++;
            $display("FAIL reset_rk got=%h exp=0", rk_out);
        end
    endtask

    task automatic test_aes128();
        push(4'd0, K128);
        push(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        push(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        push(4'd11, 128'h0);
        @(posedge clk); #1;
        launch(2'd0, {K128, 128'hdeadbeefcafef00d0123456789abcdef});
        wait_done(42, 10);
        after_done();
        drain();
    endtask

    task automatic test_illegal();
        @(posedge clk); #1;
        key_len = 2'd3;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_pulse got=%b exp=1", err);
        end
        checks++;
        if (busy !== 1'b0 || key_ready !== 1'b1) begin
            failures++;
            $display("FAIL err_state busy=%b key_ready=%b exp busy=0 key_ready=1", busy, key_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b busy=%b exp 0 0", err, busy);
        end
        push(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain();
    endtask

    task automatic test_aes192();
        push(4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        push(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        push(4'd12, 128'he98ba06f448c773c8ecc720401002202);
        push(4'd13, 128'h0);
        @(posedge clk); #1;
        launch(2'd1, {K192, 64'hffffffffffffffff});
        wait_done(48, 0);
        after_done();
        drain();
    endtask

    task automatic test_aes256();
        push(4'd8, 128'h981ccf1e5edf501fb532e109b536b9cf);
        @(posedge clk); #1;
        launch(2'd2, K256A);
        wait_done(54, 0);
        after_done();
        drain();
        push(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
        push(4'd1, 128'h101112131415161718191a1b1c1d1e1f);
        push(4'd14, RK14_B);
        push(4'd15, 128'h0);
        @(posedge clk); #1;
        launch(2'd2, K256B);
        wait_done(54, 0);
        after_done();
        drain();
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        launch(2'd2, K256B);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, key_ready} !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_ctrl got=%b exp=000", {busy, done, key_ready});
        end
        check_all_zero("rst_mid_rk");
        @(posedge clk); #1;
        rst = 1'b1;
        push(4'd14, RK14_B);
        launch(2'd2, K256B);
        wait_done(54, 0);
        after_done();
        drain();
    endtask

    task automatic test_zeroize();
`ifdef KEY_EXPAND_ZEROIZE_EN
        int saw_done;
        @(posedge clk); #1;
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        checks++;
        if (key_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_kr got=%b exp=0", key_ready);
        end
        check_all_zero("zero_rk");
        saw_done = 0;
        @(posedge clk); #1;
        launch(2'd0, {K128, 128'h0});
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 10) zeroize = 1'b1;
            if (c == 11) zeroize = 1'b0;
            if (done === 1'b1) saw_done++;
        end
        checks++;
        if (saw_done != 0 || busy !== 1'b0 || key_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_mid done_seen=%0d busy=%b key_ready=%b exp 0 0 0", saw_done, busy, key_ready);
        end
        check_all_zero("zero_mid_rk");
`else
        @(posedge clk); #1;
        zeroize = 1'b1;
        @(posedge clk); #1;
        zeroize = 1'b0;
        checks++;
        if (key_ready !== 1'b1) begin
            failures++;
            $display("FAIL zero_ignored_kr got=%b exp=1", key_ready);
        end
        push(4'd14, RK14_B);
        drain();
`endif
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        test_aes128();
        test_illegal();
        test_aes192();
        test_aes256();
        test_reset_mid();
        test_zeroize();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/key_expand_seq.md
KEY_EXPAND_SEQ -- requirements
Module: key_expand_seq

Interface
REQ-001 SHALL have parameter MAX_KEY_W, default 256, meaning the largest supported key size in bits (legal values 128, 192, 256).
REQ-002 SHALL have derived parameter NR_MAX, default 14, meaning the round count at MAX_KEY_W (10, 12 or 14).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an expansion.
REQ-006 SHALL have port key_len  input  2  key size: 0=128, 1=192, 2=256, 3=illegal.
REQ-007 SHALL have port key_in  input  MAX_KEY_W  cipher key, MSB-aligned; unused LSBs are ignored.
REQ-008 SHALL have port zeroize  input  1  key-erase request.
REQ-009 SHALL have port rk_idx  input  4  round-key read index.
REQ-010 SHALL have port rk_out  output  128  round key rk_idx, word w[4i] in bits 127:96.
REQ-011 SHALL have port busy  output  1  expansion in progress.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port key_ready  output  1  the stored schedule is valid.
REQ-014 SHALL have port err  output  1  one-cycle illegal-request pulse.

Function
REQ-015 SHALL implement the FIPS-197 key schedule with Nk = 4/6/8 and Nr = 10/12/14, using a single SubWord/RotWord/Rcon datapath that generates one 32-bit word per cycle.
REQ-016 SHALL store 4*(NR_MAX+1) words in a register array.
REQ-017 SHALL implement the FSM states IDLE, LOAD, GEN, DONE.
- IDLE -> LOAD on start with a legal key_len.
- LOAD writes w[0..Nk-1] in a single cycle.
- GEN writes w[Nk..4Nr+3], one word per cycle.
- DONE lasts one cycle, then the FSM returns to IDLE.
REQ-018 SHALL give a latency from the start edge to done equal to 1 + (4(Nr+1) - Nk) + 1 cycles: 42 for 128, 48 for 192, 54 for 256.
REQ-019 SHALL hold busy high throughout LOAD and GEN, and pulse done high only in DONE.
REQ-020 SHALL set key_ready in DONE and clear it on accepting start, on zeroize, and on reset.
REQ-021 SHALL ignore start while busy.
REQ-022 SHALL accept start while key_ready=1, dropping key_ready and re-expanding.
REQ-023 SHALL, on start with key_len=3 or a key size greater than MAX_KEY_W, pulse err for one cycle, stay in IDLE, and leave key_ready unchanged.
REQ-024 SHALL make rk_out combinational from the array; it SHALL read 0 when rk_idx > Nr of the last accepted key_len or when key_ready=0.
REQ-025 SHALL latch key_len and key_in on start; later changes to those inputs SHALL NOT affect the expansion in progress.
REQ-026 SHALL compute Rcon by doubling in GF(2^8) with polynomial 0x11B.
REQ-027 SHALL apply SubWord (without RotWord) at i mod 8 = 4, for Nk=8 only.

Reset
REQ-028 SHALL, while rst=0, asynchronously force: FSM to IDLE, busy=0, done=0, err=0, key_ready=0, key array to all zeros, and rk_out=0.
REQ-029 SHALL abort an in-progress expansion on reset; the block SHALL accept start on the first clock edge after rst rises.

Configuration
REQ-030 SHALL support macro KEY_EXPAND_ZEROIZE_EN.
- Defined: zeroize=1 clears the whole array in one cycle, aborts any expansion to IDLE without a done pulse, and clears key_ready.
- Zeroize takes priority over a simultaneous start.
REQ-031 SHALL, when KEY_EXPAND_ZEROIZE_EN is undefined, keep the zeroize port present but ignore it entirely; no clearing logic is synthesised.

Verification
REQ-032 SHALL cover AES-128.
- key 2b7e151628aed2a6abf7158809cf4f3c -> done at cycle 42.
- rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033 SHALL cover AES-192.
- key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done at cycle 48.
- rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
REQ-034 SHALL cover AES-256 with two keys.
- key 1212121269696969343434343434343456565656565656567878787878787878 -> rk_idx=8 gives 981ccf1e5edf501fb532e109b536b9cf.
- key 000102...1f -> rk_idx=14 gives 24fc79ccbf0979e9371ac23c6d68de36, with done at cycle 54.
REQ-035 SHALL cover boundary requests.
- key_len=3 -> err pulses, busy stays 0.
- start pulsed at cycle 10 of an expansion -> ignored; result unchanged.
- rk_idx=11 after AES-128 -> rk_out=0.
REQ-036 SHALL cover rst=0 at cycle 20 of an AES-256 expansion -> busy=0, key_ready=0, rk_out=0 for all indices; a new start afterwards completes correctly.
REQ-037 SHALL cover zeroize=1 with KEY_EXPAND_ZEROIZE_EN defined, both after done and mid-GEN -> key_ready=0, all rk_out=0, no done pulse.
